// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the two-port RAM arbiter: widths, FSM
// encodings, port ids and the latched command record.
package ram_arbiter_pkg;
  localparam int DATA_W = 14;
  localparam int ADDR_W = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef struct packed {
    logic  winner;
    logic  we;
    addr_t addr;
    word_t wdata;
  } cmd_t;

  function automatic logic other_port(input logic port);
    return ~port;
  endfunction
endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of both requester handshakes plus the RAM port; the arbiter takes
// the slave view, requesters and the RAM model take the master view.
interface ram_arbiter_if;
  import ram_arbiter_pkg::*;

  logic  p0_req;
  logic  p0_we;
  addr_t p0_addr;
  word_t p0_wdata;
  logic  p0_ack;
  word_t p0_rdata;

  logic  p1_req;
  logic  p1_we;
  addr_t p1_addr;
  word_t p1_wdata;
  logic  p1_ack;
  word_t p1_rdata;

  logic  ram_write;
  addr_t ram_addr;
  word_t ram_din;
  word_t ram_dout;
  logic  busy;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  ram_dout,
    output p0_ack, p0_rdata, p1_ack, p1_rdata,
    output ram_write, ram_addr, ram_din, busy
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output ram_dout,
    input  p0_ack, p0_rdata, p1_ack, p1_rdata,
    input  ram_write, ram_addr, ram_din, busy
  );
endinterface

// File: rtl/ram_arbiter_rr_pick2.sv
// Combinational two-way winner select: a lone request wins outright; a tie
// goes to port 0 under fixed priority, else to the port that did not win last.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last_winner,
  input  logic fixed_prio,
  output logic winner,
  output logic any_req
);
  import ram_arbiter_pkg::*;

  // Winner selection for the current IDLE sample
  always_comb begin
    winner = PORT0;
    if (req0 && req1) begin
      if (fixed_prio) begin
        winner = PORT0;
      end else begin
        winner = other_port(last_winner);
      end
    end else if (req1) begin
      winner = PORT1;
    end else begin
      winner = PORT0;
    end
  end

  assign any_req = req0 | req1;
endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates the single-port 256x14 data RAM between the processor (port 0)
// and the host loader (port 1): one access per three cycles, fixed latency.
module ram_arbiter #(
  parameter int FIXED_PRIO = 0
) (
  input logic         clk,
  input logic         rst_n,
  ram_arbiter_if.slave bus
);
  import ram_arbiter_pkg::*;

  localparam logic FIXED_PRIO_EN = (FIXED_PRIO != 0);

  logic [1:0] state_r;
  logic [1:0] state_nxt_s;
  logic       last_winner_r;
  cmd_t       cmd_r;
  cmd_t       sel_cmd_s;
  logic       ram_write_r;
  logic       p0_ack_r;
  logic       p1_ack_r;
  word_t      p0_rdata_r;
  word_t      p1_rdata_r;
  logic       pick_winner_s;
  logic       any_req_s;

  rr_pick2 u_pick (
    .req0        (bus.p0_req),
    .req1        (bus.p1_req),
    .last_winner (last_winner_r),
    .fixed_prio  (FIXED_PRIO_EN),
    .winner      (pick_winner_s),
    .any_req     (any_req_s)
  );

  // Next-state decode; requests only matter in IDLE
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          state_nxt_s = ST_GRANT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GRANT: state_nxt_s = ST_DONE;
      ST_DONE:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Mux the winning port's command fields
  always_comb begin
    sel_cmd_s = '0;
    if (pick_winner_s == PORT1) begin
      sel_cmd_s.winner = PORT1;
      sel_cmd_s.we     = bus.p1_we;
      sel_cmd_s.addr   = bus.p1_addr;
      sel_cmd_s.wdata  = bus.p1_wdata;
    end else begin
      sel_cmd_s.winner = PORT0;
      sel_cmd_s.we     = bus.p0_we;
      sel_cmd_s.addr   = bus.p0_addr;
      sel_cmd_s.wdata  = bus.p0_wdata;
    end
  end

  // FSM state, frozen command registers and round-robin history
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      cmd_r         <= '0;
      last_winner_r <= PORT1;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == ST_IDLE && any_req_s) begin
        cmd_r <= sel_cmd_s;
      end
      if (state_r == ST_GRANT) begin
        last_winner_r <= cmd_r.winner;
      end
    end
  end

  // Write strobe (high for the GRANT cycle only), acks and read-data capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ram_write_r <= 1'b0;
      p0_ack_r    <= 1'b0;
      p1_ack_r    <= 1'b0;
      p0_rdata_r  <= '0;
      p1_rdata_r  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          p0_ack_r    <= 1'b0;
          p1_ack_r    <= 1'b0;
          ram_write_r <= any_req_s & sel_cmd_s.we;
        end
        ST_GRANT: begin
          ram_write_r <= 1'b0;
          p0_ack_r    <= (cmd_r.winner == PORT0);
          p1_ack_r    <= (cmd_r.winner == PORT1);
          if (!cmd_r.we && cmd_r.winner == PORT1) begin
            p1_rdata_r <= bus.ram_dout;
          end
          if (!cmd_r.we && cmd_r.winner == PORT0) begin
            p0_rdata_r <= bus.ram_dout;
          end
        end
        ST_DONE: begin
          ram_write_r <= 1'b0;
          p0_ack_r    <= 1'b0;
          p1_ack_r    <= 1'b0;
        end
        default: begin
          ram_write_r <= 1'b0;
          p0_ack_r    <= 1'b0;
          p1_ack_r    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ram_write = ram_write_r;
  assign bus.ram_addr  = cmd_r.addr;
  assign bus.ram_din   = cmd_r.wdata;
  assign bus.p0_ack    = p0_ack_r;
  assign bus.p1_ack    = p1_ack_r;
  assign bus.p0_rdata  = p0_rdata_r;
  assign bus.p1_rdata  = p1_rdata_r;
  assign bus.busy      = (state_r != ST_IDLE);
endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench: a round-robin arbiter with a behavioural RAM, plus a
// fixed-priority instance for the starvation scenario.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  typedef struct packed {
    logic        port;
    logic        we;
    logic [13:0] data;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  exp_t        sb_q[$];
  logic [13:0] ref_mem [256];
  logic [13:0] exp_rd [2];
  logic [13:0] mem_rr [256] = '{default: 14'h0};

  ram_arbiter_if bus_rr();
  ram_arbiter_if bus_fp();

  ram_arbiter #(.FIXED_PRIO(0)) dut_rr (.clk(clk), .rst_n(rst_n), .bus(bus_rr));
  ram_arbiter #(.FIXED_PRIO(1)) dut_fp (.clk(clk), .rst_n(rst_n), .bus(bus_fp));

  function automatic logic [13:0] pat(input logic [7:0] a);
    return {a[5:0], ~a};
  endfunction

  // Unwritten words read back as pat(addr)
  assign bus_rr.ram_dout = mem_rr[bus_rr.ram_addr] ^ pat(bus_rr.ram_addr);
  assign bus_fp.ram_dout = pat(bus_fp.ram_addr);

  always @(posedge clk) begin
    if (bus_rr.ram_write) mem_rr[bus_rr.ram_addr] <= bus_rr.ram_din ^ pat(bus_rr.ram_addr);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic drive_p0(input logic req, input logic we, input logic [7:0] a, input logic [13:0] d);
    bus_rr.p0_req = req; bus_rr.p0_we = we; bus_rr.p0_addr = a; bus_rr.p0_wdata = d;
  endtask

  task automatic drive_p1(input logic req, input logic we, input logic [7:0] a, input logic [13:0] d);
    bus_rr.p1_req = req; bus_rr.p1_we = we; bus_rr.p1_addr = a; bus_rr.p1_wdata = d;
  endtask

  task automatic push_exp(input logic port, input logic we, input logic [7:0] a, input logic [13:0] d);
    exp_t e;
    if (we) ref_mem[a] = d;
    e.port = port;
    e.we   = we;
    e.data = we ? 14'h0 : ref_mem[a];
    sb_q.push_back(e);
  endtask

  // Advance to the next falling edge and service the scoreboard
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (bus_rr.ram_write === 1'b1) begin
      n_cmp++;
      if (bus_rr.busy !== 1'b1 || bus_rr.p0_ack !== 1'b0 || bus_rr.p1_ack !== 1'b0) begin
        n_err++;
        $display("FAIL ram_write_window: busy=%b acks=%b%b, required busy=1 acks=00",
                 bus_rr.busy, bus_rr.p0_ack, bus_rr.p1_ack);
      end
    end
    if (bus_rr.p0_ack === 1'b1 || bus_rr.p1_ack === 1'b1) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_ack: p0_ack=%b p1_ack=%b, required no ack",
                 bus_rr.p0_ack, bus_rr.p1_ack);
      end else begin
        e = sb_q.pop_front();
        if (bus_rr.p0_ack !== (e.port == 1'b0) || bus_rr.p1_ack !== (e.port == 1'b1)) begin
          n_err++;
          $display("FAIL ack_port: acks p0=%b p1=%b, required port %0d only",
                   bus_rr.p0_ack, bus_rr.p1_ack, e.port);
        end
        if (!e.we) exp_rd[e.port] = e.data;
        n_cmp++;
        if (bus_rr.p0_rdata !== exp_rd[0]) begin
          n_err++;
          $display("FAIL p0_rdata: got %h, required %h", bus_rr.p0_rdata, exp_rd[0]);
        end
        n_cmp++;
        if (bus_rr.p1_rdata !== exp_rd[1]) begin
          n_err++;
          $display("FAIL p1_rdata: got %h, required %h", bus_rr.p1_rdata, exp_rd[1]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    exp_rd[0] = 14'h0;
    exp_rd[1] = 14'h0;
    n_cmp++;
    if ({bus_rr.busy, bus_rr.p0_ack, bus_rr.p1_ack, bus_rr.ram_write} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_ctrl: busy/ack0/ack1/we=%b, required 0000",
               {bus_rr.busy, bus_rr.p0_ack, bus_rr.p1_ack, bus_rr.ram_write});
    end
    n_cmp++;
    if (bus_rr.ram_addr !== 8'h00 || bus_rr.ram_din !== 14'h0) begin
      n_err++;
      $display("FAIL reset_ram: addr=%h din=%h, required 00/0000", bus_rr.ram_addr, bus_rr.ram_din);
    end
    n_cmp++;
    if (bus_rr.p0_rdata !== 14'h0 || bus_rr.p1_rdata !== 14'h0) begin
      n_err++;
      $display("FAIL reset_rdata: p0=%h p1=%h, required 0000", bus_rr.p0_rdata, bus_rr.p1_rdata);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_round_robin();
    push_exp(1'b0, 1'b0, 8'd10, 14'h0);
    push_exp(1'b1, 1'b0, 8'd20, 14'h0);
    drive_p0(1'b1, 1'b0, 8'd10, 14'h0);
    drive_p1(1'b1, 1'b0, 8'd20, 14'h0);
    repeat (2) tick();
    n_cmp++;
    if (bus_rr.p0_ack !== 1'b1 || bus_rr.p1_ack !== 1'b0) begin
      n_err++;
      $display("FAIL rr_tie1_first: acks=%b%b, required p0 only", bus_rr.p0_ack, bus_rr.p1_ack);
    end
    tick();
    drive_p0(1'b0, 1'b0, 8'd0, 14'h0);
    repeat (2) tick();
    n_cmp++;
    if (bus_rr.p1_ack !== 1'b1) begin
      n_err++;
      $display("FAIL rr_tie1_second: p1_ack=%b, required 1", bus_rr.p1_ack);
    end
    tick();
    drive_p1(1'b0, 1'b0, 8'd0, 14'h0);
    tick();
    push_exp(1'b0, 1'b0, 8'd30, 14'h0);
    drive_p0(1'b1, 1'b0, 8'd30, 14'h0);
    repeat (3) tick();
    drive_p0(1'b0, 1'b0, 8'd0, 14'h0);
    tick();
    // port 0 won last, so this tie goes to port 1
    push_exp(1'b1, 1'b0, 8'd40, 14'h0);
    push_exp(1'b0, 1'b0, 8'd50, 14'h0);
    drive_p0(1'b1, 1'b0, 8'd50, 14'h0);
    drive_p1(1'b1, 1'b0, 8'd40, 14'h0);
    repeat (2) tick();
    n_cmp++;
    if (bus_rr.p1_ack !== 1'b1 || bus_rr.p0_ack !== 1'b0) begin
      n_err++;
      $display("FAIL rr_tie2_first: acks=%b%b, required p1 only", bus_rr.p0_ack, bus_rr.p1_ack);
    end
    tick();
    drive_p1(1'b0, 1'b0, 8'd0, 14'h0);
    repeat (2) tick();
    n_cmp++;
    if (bus_rr.p0_ack !== 1'b1) begin
      n_err++;
      $display("FAIL rr_tie2_second: p0_ack=%b, required 1", bus_rr.p0_ack);
    end
    tick();
    drive_p0(1'b0, 1'b0, 8'd0, 14'h0);
    tick();
  endtask

  task automatic test_write_read();
    push_exp(1'b0, 1'b1, 8'd5, 14'h1ABC);
    drive_p0(1'b1, 1'b1, 8'd5, 14'h1ABC);
    tick();
    n_cmp++;
    if (bus_rr.ram_write !== 1'b1 || bus_rr.ram_addr !== 8'd5 || bus_rr.ram_din !== 14'h1ABC) begin
      n_err++;
      $display("FAIL grant_drive: we=%b addr=%h din=%h, required 1/05/1abc",
               bus_rr.ram_write, bus_rr.ram_addr, bus_rr.ram_din);
    end
    tick();
    n_cmp++;
    if (bus_rr.p0_ack !== 1'b1 || bus_rr.ram_write !== 1'b0) begin
      n_err++;
      $display("FAIL write_done: ack=%b we=%b, required ack=1 we=0", bus_rr.p0_ack, bus_rr.ram_write);
    end
    tick();
    drive_p0(1'b0, 1'b0, 8'd0, 14'h0);
    n_cmp++;
    if (bus_rr.busy !== 1'b0 || bus_rr.ram_write !== 1'b0 || bus_rr.p0_ack !== 1'b0) begin
      n_err++;
      $display("FAIL after_write: busy=%b we=%b ack=%b, required 000",
               bus_rr.busy, bus_rr.ram_write, bus_rr.p0_ack);
    end
    tick();
    push_exp(1'b0, 1'b0, 8'd5, 14'h0);
    drive_p0(1'b1, 1'b0, 8'd5, 14'h0);
    repeat (2) tick();
    n_cmp++;
    if (bus_rr.p0_rdata !== 14'h1ABC) begin
      n_err++;
      $display("FAIL readback_5: got %h, required 1abc", bus_rr.p0_rdata);
    end
    tick();
    drive_p0(1'b0, 1'b0, 8'd0, 14'h0);
    tick();
  endtask

  task automatic test_cross_port();
    logic [13:0] p1_before;
    p1_before = exp_rd[1];
    push_exp(1'b1, 1'b1, 8'd255, 14'h3FFF);
    push_exp(1'b0, 1'b0, 8'd255, 14'h0);
    drive_p1(1'b1, 1'b1, 8'd255, 14'h3FFF);
    drive_p0(1'b1, 1'b0, 8'd255, 14'h0);
    repeat (3) tick();
    drive_p1(1'b0, 1'b0, 8'd0, 14'h0);
    repeat (2) tick();
    n_cmp++;
    if (bus_rr.p0_ack !== 1'b1 || bus_rr.p0_rdata !== 14'h3FFF) begin
      n_err++;
      $display("FAIL cross_read: ack=%b rdata=%h, required 1/3fff", bus_rr.p0_ack, bus_rr.p0_rdata);
    end
    n_cmp++;
    if (bus_rr.p1_rdata !== p1_before) begin
      n_err++;
      $display("FAIL writer_rdata: got %h, required %h", bus_rr.p1_rdata, p1_before);
    end
    tick();
    drive_p0(1'b0, 1'b0, 8'd0, 14'h0);
    tick();
  endtask

  task automatic test_back_to_back();
    push_exp(1'b0, 1'b0, 8'd77, 14'h0);
    push_exp(1'b0, 1'b0, 8'd77, 14'h0);
    drive_p0(1'b1, 1'b0, 8'd77, 14'h0);
    repeat (3) tick();
    n_cmp++;
    if (bus_rr.p0_ack !== 1'b0 || bus_rr.busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_gap: ack=%b busy=%b, required 0/0", bus_rr.p0_ack, bus_rr.busy);
    end
    repeat (2) tick();
    n_cmp++;
    if (bus_rr.p0_ack !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_second_ack: got %b, required 1", bus_rr.p0_ack);
    end
    tick();
    drive_p0(1'b0, 1'b0, 8'd0, 14'h0);
    tick();
  endtask

  task automatic test_reset_mid_grant();
    drive_p0(1'b1, 1'b1, 8'd7, 14'h0AAA);
    tick();
    n_cmp++;
    if (bus_rr.ram_write !== 1'b1) begin
      n_err++;
      $display("FAIL abort_grant_we: got %b, required 1", bus_rr.ram_write);
    end
    rst_n = 1'b0;
    tick();
    drive_p0(1'b0, 1'b0, 8'd0, 14'h0);
    exp_rd[0] = 14'h0;
    exp_rd[1] = 14'h0;
    n_cmp++;
    if ({bus_rr.p0_ack, bus_rr.busy, bus_rr.ram_write} !== 3'b000 || bus_rr.p0_rdata !== 14'h0) begin
      n_err++;
      $display("FAIL abort_state: ack/busy/we=%b rdata=%h, required 000/0000",
               {bus_rr.p0_ack, bus_rr.busy, bus_rr.ram_write}, bus_rr.p0_rdata);
    end
    tick();
    rst_n = 1'b1;
    tick();
    push_exp(1'b0, 1'b0, 8'd50, 14'h0);
    push_exp(1'b1, 1'b0, 8'd60, 14'h0);
    drive_p0(1'b1, 1'b0, 8'd50, 14'h0);
    drive_p1(1'b1, 1'b0, 8'd60, 14'h0);
    repeat (2) tick();
    n_cmp++;
    if (bus_rr.p0_ack !== 1'b1 || bus_rr.p1_ack !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_tie: acks=%b%b, required p0 only", bus_rr.p0_ack, bus_rr.p1_ack);
    end
    tick();
    drive_p0(1'b0, 1'b0, 8'd0, 14'h0);
    repeat (3) tick();
    drive_p1(1'b0, 1'b0, 8'd0, 14'h0);
    tick();
  endtask

  task automatic test_fixed_prio();
    bus_fp.p0_req = 1'b1; bus_fp.p0_we = 1'b0; bus_fp.p0_addr = 8'd3;
    bus_fp.p1_req = 1'b1; bus_fp.p1_we = 1'b0; bus_fp.p1_addr = 8'd4;
    for (int k = 0; k < 4; k++) begin
      repeat (2) @(negedge clk);
      n_cmp++;
      if (bus_fp.p0_ack !== 1'b1 || bus_fp.p1_ack !== 1'b0 || bus_fp.p0_rdata !== pat(8'd3)) begin
        n_err++;
        $display("FAIL fp_ack%0d: acks=%b%b rdata=%h, required p0 only / %h",
                 k, bus_fp.p0_ack, bus_fp.p1_ack, bus_fp.p0_rdata, pat(8'd3));
      end
      @(negedge clk);
    end
    bus_fp.p0_req = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus_fp.p1_ack !== 1'b1 || bus_fp.p0_ack !== 1'b0 || bus_fp.p1_rdata !== pat(8'd4)) begin
      n_err++;
      $display("FAIL fp_p1_served: acks=%b%b rdata=%h, required p1 only / %h",
               bus_fp.p0_ack, bus_fp.p1_ack, bus_fp.p1_rdata, pat(8'd4));
    end
    @(negedge clk);
    bus_fp.p1_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = pat(8'(i));
    drive_p0(1'b0, 1'b0, 8'd0, 14'h0);
    drive_p1(1'b0, 1'b0, 8'd0, 14'h0);
    bus_fp.p0_req = 1'b0; bus_fp.p0_we = 1'b0; bus_fp.p0_addr = 8'd0; bus_fp.p0_wdata = 14'h0;
    bus_fp.p1_req = 1'b0; bus_fp.p1_we = 1'b0; bus_fp.p1_addr = 8'd0; bus_fp.p1_wdata = 14'h0;

    test_reset();
    test_round_robin();
    test_write_read();
    test_cross_port();
    test_back_to_back();
    test_reset_mid_grant();
    test_fixed_prio();

    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL pending_acks: %0d outstanding, required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
